// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle bit positions and FSM encoding.
package id_ex_pipe_pkg;

  localparam int CTRL_W = 13;

  localparam int CTRL_JAL       = 12;
  localparam int CTRL_J         = 11;
  localparam int CTRL_REGDST    = 10;
  localparam int CTRL_ALUSRC    = 9;
  localparam int CTRL_MEMTOREG  = 8;
  localparam int CTRL_REGWRITE  = 7;
  localparam int CTRL_MEMREAD   = 6;
  localparam int CTRL_MEMWRITE  = 5;
  localparam int CTRL_BNE       = 4;
  localparam int CTRL_BEQ       = 3;
  localparam int CTRL_ALUOP_MSB = 2;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

endpackage

// File: rtl/id_ex_pipe_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX stage.
interface id_ex_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  import id_ex_pipe_pkg::*;

  logic                  id_valid;
  ctrl_t                 id_ctrl;
  logic [4:0]            id_rs, id_rt, id_rd;
  logic [DATA_WIDTH-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic                  hold;
  logic                  flush;

  logic                  ex_valid;
  ctrl_t                 ex_ctrl;
  logic [4:0]            ex_rs, ex_rt, ex_rd;
  logic [DATA_WIDTH-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic                  stall;
  logic [CNT_WIDTH-1:0]  bubble_count;

  modport master (
    output id_valid, id_ctrl, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_pc4, hold, flush,
    input  ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, stall, bubble_count
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_pc4, hold, flush,
    output ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, stall, bubble_count
  );

endinterface

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard check between the load sitting in EX and the instruction in decode.
module id_ex_pipe_hazard_detect (
  input  logic       run_i,
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic       id_valid_i,
  input  logic [3:0] id_rt_src_i,  // {RegDst, MemWrite, BranchNE, BranchEQ}
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       hazard_o
);

  logic rt_used;
  logic load_in_ex;

  assign rt_used    = |id_rt_src_i;
  // $0 is never a real dependency, so a load into it cannot stall anyone
  assign load_in_ex = run_i & ex_valid_i & ex_memread_i & (ex_rt_i != 5'd0);
  assign hazard_o   = load_in_ex & id_valid_i &
                      ((ex_rt_i == id_rs_i) | (rt_used & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush and a saturating bubble counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_pipe_if.slave  bus
);

  state_e                state_q;
  logic                  ex_valid_q;
  ctrl_t                 ex_ctrl_q;
  logic [4:0]            ex_rs_q, ex_rt_q, ex_rd_q;
  logic [DATA_WIDTH-1:0] ex_rs_data_q, ex_rt_data_q, ex_imm_q, ex_pc4_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  hazard;

  id_ex_pipe_hazard_detect u_hazard (
    .run_i        (state_q == RUN),
    .ex_valid_i   (ex_valid_q),
    .ex_memread_i (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i      (ex_rt_q),
    .id_valid_i   (bus.id_valid),
    .id_rt_src_i  ({bus.id_ctrl[CTRL_REGDST], bus.id_ctrl[CTRL_MEMWRITE],
                    bus.id_ctrl[CTRL_BNE], bus.id_ctrl[CTRL_BEQ]}),
    .id_rs_i      (bus.id_rs),
    .id_rt_i      (bus.id_rt),
    .hazard_o     (hazard)
  );

  assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign bus.stall = (hazard | bus.hold) & ~bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_pc4_q     <= '0;
      cnt_q        <= '0;
    end else if (bus.flush) begin
      // Data registers are left alone: nothing downstream looks at them without ex_valid.
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      state_q    <= RUN;
    end else if (!bus.hold) begin
      if (hazard) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= '0;
        state_q    <= BUBBLE;
        cnt_q      <= cnt_d;
      end else begin
        ex_valid_q   <= bus.id_valid;
        ex_ctrl_q    <= bus.id_valid ? bus.id_ctrl : '0;
        ex_rs_q      <= bus.id_rs;
        ex_rt_q      <= bus.id_rt;
        ex_rd_q      <= bus.id_rd;
        ex_rs_data_q <= bus.id_rs_data;
        ex_rt_data_q <= bus.id_rt_data;
        ex_imm_q     <= bus.id_imm;
        ex_pc4_q     <= bus.id_pc4;
        state_q      <= RUN;
      end
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_rs_data   = ex_rs_data_q;
  assign bus.ex_rt_data   = ex_rt_data_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_pc4       = ex_pc4_q;
  assign bus.bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: vector table with a scoreboard queue, plus reset/saturation sequences.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int SCW = 3;   // narrow counter instance so saturation is reachable quickly

  localparam ctrl_t C_ADD  = 13'h0482;  // RegDst RegWrite ALUOp=2
  localparam ctrl_t C_LW   = 13'h03C0;  // ALUSrc MemtoReg RegWrite MemRead
  localparam ctrl_t C_ADDI = 13'h0280;  // ALUSrc RegWrite
  localparam ctrl_t C_SW   = 13'h0220;  // ALUSrc MemWrite
  localparam ctrl_t C_BEQ  = 13'h0009;  // BranchEQ ALUOp=1

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW))  bus ();
  id_ex_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(SCW)) sbus ();

  id_ex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW))  dut     (.clk(clk), .reset(reset), .bus(bus));
  id_ex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(SCW)) dut_sat (.clk(clk), .reset(reset), .bus(sbus));

  typedef struct {
    logic v; ctrl_t ctrl; logic [4:0] rs, rt; logic hold, flush; logic [7:0] tag;
    logic exp_stall, exp_v; ctrl_t exp_ctrl; logic [7:0] exp_tag;
    logic [4:0] exp_rs, exp_rt; logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic v; ctrl_t ctrl; logic [7:0] tag; logic [4:0] rs, rt; logic [15:0] cnt;
  } exp_t;

  vec_t vt[23];
  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic v, ctrl_t c, logic [4:0] rs, logic [4:0] rt, logic h, logic f,
                              logic [7:0] tag, logic es, logic ev, ctrl_t ec, logic [7:0] et,
                              logic [4:0] ers, logic [4:0] ert, logic [15:0] ecnt);
    vec_t x;
    x.v = v; x.ctrl = c; x.rs = rs; x.rt = rt; x.hold = h; x.flush = f; x.tag = tag;
    x.exp_stall = es; x.exp_v = ev; x.exp_ctrl = ec; x.exp_tag = et;
    x.exp_rs = ers; x.exp_rt = ert; x.exp_cnt = ecnt;
    return x;
  endfunction

  function automatic logic [31:0] rs_d(logic [7:0] t);  return {24'hA1B2C3, t}; endfunction
  function automatic logic [31:0] rt_d(logic [7:0] t);  return {24'hD4E5F6, t}; endfunction
  function automatic logic [31:0] imm_d(logic [7:0] t); return {24'hFFFF80, t}; endfunction
  function automatic logic [31:0] pc_d(logic [7:0] t);  return {24'h004000, t}; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic h, input logic f, input logic [7:0] tag);
    bus.id_valid   = v;
    bus.id_ctrl    = c;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = tag[4:0];
    bus.id_rs_data = rs_d(tag);
    bus.id_rt_data = rt_d(tag);
    bus.id_imm     = imm_d(tag);
    bus.id_pc4     = pc_d(tag);
    bus.hold       = h;
    bus.flush      = f;
  endtask

  task automatic sdrive(input logic v, input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt);
    sbus.id_valid   = v;
    sbus.id_ctrl    = c;
    sbus.id_rs      = rs;
    sbus.id_rt      = rt;
    sbus.id_rd      = 5'd1;
    sbus.id_rs_data = '0;
    sbus.id_rt_data = '0;
    sbus.id_imm     = '0;
    sbus.id_pc4     = '0;
    sbus.hold       = 1'b0;
    sbus.flush      = 1'b0;
  endtask

  initial begin
    exp_t e;
    //           v  ctrl    rs rt h f tag  stl ev ectrl   etag ers ert cnt
    vt[0]  = mk(1, C_ADD,  1, 2, 0, 0, 1,   0, 1, C_ADD,  1,   1, 2, 0);
    vt[1]  = mk(1, C_LW,   1, 8, 0, 0, 2,   0, 1, C_LW,   2,   1, 8, 0);
    vt[2]  = mk(1, C_ADD,  8, 2, 0, 0, 3,   1, 0, 0,      0,   0, 0, 1);
    vt[3]  = mk(1, C_ADD,  8, 2, 0, 0, 3,   0, 1, C_ADD,  3,   8, 2, 1);
    vt[4]  = mk(1, C_LW,   1, 0, 0, 0, 5,   0, 1, C_LW,   5,   1, 0, 1);
    vt[5]  = mk(1, C_ADD,  0, 0, 0, 0, 6,   0, 1, C_ADD,  6,   0, 0, 1);
    vt[6]  = mk(1, C_LW,   1, 8, 0, 0, 7,   0, 1, C_LW,   7,   1, 8, 1);
    vt[7]  = mk(1, C_ADDI, 9, 8, 0, 0, 8,   0, 1, C_ADDI, 8,   9, 8, 1);
    vt[8]  = mk(1, C_LW,   1, 8, 0, 0, 9,   0, 1, C_LW,   9,   1, 8, 1);
    vt[9]  = mk(1, C_SW,   1, 8, 0, 0, 10,  1, 0, 0,      0,   0, 0, 2);
    vt[10] = mk(1, C_SW,   1, 8, 0, 0, 10,  0, 1, C_SW,   10,  1, 8, 2);
    vt[11] = mk(1, C_LW,   1, 5, 0, 0, 12,  0, 1, C_LW,   12,  1, 5, 2);
    vt[12] = mk(1, C_BEQ,  1, 5, 0, 1, 13,  0, 0, 0,      0,   0, 0, 2);
    vt[13] = mk(1, C_BEQ,  1, 5, 0, 0, 14,  0, 1, C_BEQ,  14,  1, 5, 2);
    vt[14] = mk(1, C_LW,   1, 6, 0, 0, 15,  0, 1, C_LW,   15,  1, 6, 2);
    vt[15] = mk(1, C_ADD,  6, 2, 1, 0, 16,  1, 1, C_LW,   15,  1, 6, 2);
    vt[16] = mk(1, C_ADD,  7, 2, 1, 0, 17,  1, 1, C_LW,   15,  1, 6, 2);
    vt[17] = mk(1, C_ADDI, 7, 3, 1, 0, 18,  1, 1, C_LW,   15,  1, 6, 2);
    vt[18] = mk(1, C_ADD,  6, 2, 0, 0, 19,  1, 0, 0,      0,   0, 0, 3);
    vt[19] = mk(1, C_ADD,  6, 2, 0, 0, 19,  0, 1, C_ADD,  19,  6, 2, 3);
    vt[20] = mk(0, C_LW,   6, 6, 0, 0, 21,  0, 0, 0,      21,  6, 6, 3);
    vt[21] = mk(1, C_LW,   1, 9, 0, 0, 22,  0, 1, C_LW,   22,  1, 9, 3);
    vt[22] = mk(1, C_ADD,  9, 2, 1, 1, 23,  0, 0, 0,      0,   0, 0, 3);

    // Reset with busy inputs: everything must read zero.
    reset = 1'b0;
    drive(1, C_LW, 8, 8, 0, 0, 8'h55);
    sdrive(1, C_LW, 8, 8);
    repeat (2) @(posedge clk);
    #1;
    chk("rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst ex_ctrl", {19'd0, bus.ex_ctrl}, 32'd0);
    chk("rst ex_rt", {27'd0, bus.ex_rt}, 32'd0);
    chk("rst ex_rs_data", bus.ex_rs_data, 32'd0);
    chk("rst ex_pc4", bus.ex_pc4, 32'd0);
    chk("rst bubble_count", {16'd0, bus.bubble_count}, 32'd0);
    chk("rst stall", {31'd0, bus.stall}, 32'd0);

    @(negedge clk);
    drive(0, '0, 0, 0, 0, 0, 0);
    sdrive(0, '0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].ctrl, vt[i].rs, vt[i].rt, vt[i].hold, vt[i].flush, vt[i].tag);
      e.v = vt[i].exp_v; e.ctrl = vt[i].exp_ctrl; e.tag = vt[i].exp_tag;
      e.rs = vt[i].exp_rs; e.rt = vt[i].exp_rt; e.cnt = vt[i].exp_cnt;
      sb.push_back(e);
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, bus.stall}, {31'd0, vt[i].exp_stall});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, e.v});
      chk($sformatf("v%0d ex_ctrl", i), {19'd0, bus.ex_ctrl}, {19'd0, e.ctrl});
      chk($sformatf("v%0d bubble_count", i), {16'd0, bus.bubble_count}, {16'd0, e.cnt});
      if (e.tag != 8'd0) begin
        chk($sformatf("v%0d ex_rs", i), {27'd0, bus.ex_rs}, {27'd0, e.rs});
        chk($sformatf("v%0d ex_rt", i), {27'd0, bus.ex_rt}, {27'd0, e.rt});
        chk($sformatf("v%0d ex_rd", i), {27'd0, bus.ex_rd}, {27'd0, e.tag[4:0]});
        chk($sformatf("v%0d ex_rs_data", i), bus.ex_rs_data, rs_d(e.tag));
        chk($sformatf("v%0d ex_rt_data", i), bus.ex_rt_data, rt_d(e.tag));
        chk($sformatf("v%0d ex_imm", i), bus.ex_imm, imm_d(e.tag));
        chk($sformatf("v%0d ex_pc4", i), bus.ex_pc4, pc_d(e.tag));
      end
    end

    // Reset asserted and released while hold is high: stage comes back empty.
    @(negedge clk);
    drive(1, C_LW, 1, 8, 0, 0, 30);
    @(posedge clk);
    #1;
    chk("pre-rst load", {31'd0, bus.ex_valid}, 32'd1);
    @(negedge clk);
    drive(1, C_ADD, 4, 4, 1, 0, 31);
    reset = 1'b0;
    #1;
    chk("async rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("async rst bubble_count", {16'd0, bus.bubble_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("hold after rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("hold after rst stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    drive(1, C_ADD, 8, 2, 0, 0, 32);
    #1;
    chk("run after rst stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("run after rst ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("run after rst ex_ctrl", {19'd0, bus.ex_ctrl}, {19'd0, C_ADD});
    chk("run after rst ex_rs_data", bus.ex_rs_data, rs_d(8'd32));

    // Saturation on the narrow-counter instance: 9 load-use pairs, ceiling 7.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      sdrive(1, C_LW, 1, 8);
      @(negedge clk);
      sdrive(1, C_ADD, 8, 3);
      #1;
      chk($sformatf("sat%0d stall", k), {31'd0, sbus.stall}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d count", k), {29'd0, sbus.bubble_count}, (k > 7) ? 32'd7 : k);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d dep loaded", k), {31'd0, sbus.ex_valid}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
